// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array result streamer.
// Used by sa_result_streamer (optional feature macro: SA_STREAM_DBUF_EN).
package sa_pkg;

    localparam int SA_SIZE       = 2;
    localparam int SA_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sa_state_t;

    // Bit offset of element (row, col) inside the flattened row-major result bus.
    function automatic int elem_offset(input int row, input int col,
                                       input int size, input int dw);
        return (row * size + col) * dw;
    endfunction

endpackage

// File: rtl/sa_result_streamer_if.sv
// Valid/ready element stream carrying one result element plus its coordinates.
interface sa_result_streamer_if #(
    parameter int SIZE       = 2,
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_W-1:0]      out_row;
    logic [IDX_W-1:0]      out_col;
    logic                  out_last;

    modport master (
        output out_data, out_valid, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_row, out_col, out_last,
        output out_ready
    );

endinterface

// File: rtl/sa_result_buf.sv
// Capture register bank for one SIZE x SIZE matrix with an indexed element mux.
module sa_result_buf
    import sa_pkg::*;
#(
    parameter int SIZE       = SA_SIZE,
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int CNT_W      = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0]   data_in,
    input  logic [CNT_W-1:0]                  idx,
    output logic [DATA_WIDTH-1:0]             elem,
    output logic [SIZE*SIZE*DATA_WIDTH-1:0]   data_all
);
    localparam int N = SIZE * SIZE;

    logic [N*DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0]   elems [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= data_in;
        end
    end

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
            for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
                assign elems[gi*SIZE+gj] =
                    data_reg[elem_offset(gi, gj, SIZE, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    endgenerate

    always_comb begin
        elem = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == CNT_W'(k)) begin
                elem = elems[k];
            end
        end
    end

    assign data_all = data_reg;

endmodule

// File: rtl/sa_result_streamer.sv
// Captures the systolic array's parallel result on done_in and streams it row-major,
// one element per valid/ready beat. Define SA_STREAM_DBUF_EN for a second pending buffer.
module sa_result_streamer
    import sa_pkg::*;
#(
    parameter int SIZE       = SA_SIZE,
    parameter int DATA_WIDTH = SA_DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0] C_in,
    input  logic                            done_in,
    sa_result_streamer_if.master            res,
    output logic                            busy,
    output logic                            overrun
);
    localparam int N     = SIZE * SIZE;
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    sa_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  index_reg, index_next;
    logic              overrun_reg, overrun_next;
    logic              shadow_load;
    logic              handshake;
    logic              at_last;
    logic [DATA_WIDTH-1:0]       shadow_elem;
    logic [N*DATA_WIDTH-1:0]     shadow_src;
    logic [N*DATA_WIDTH-1:0]     shadow_all_unused;

`ifdef SA_STREAM_DBUF_EN
    logic                        pend_valid_reg, pend_valid_next;
    logic                        pend_load;
    logic                        from_pend;
    logic [N*DATA_WIDTH-1:0]     pend_all;
    logic [DATA_WIDTH-1:0]       pend_elem_unused;

    sa_result_buf #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_pend_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (pend_load),
        .data_in  (C_in),
        .idx      ('0),
        .elem     (pend_elem_unused),
        .data_all (pend_all)
    );

    assign shadow_src = from_pend ? pend_all : C_in;
`else
    assign shadow_src = C_in;
`endif

    sa_result_buf #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_shadow_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (shadow_load),
        .data_in  (shadow_src),
        .idx      (index_reg),
        .elem     (shadow_elem),
        .data_all (shadow_all_unused)
    );

    assign handshake = (state_reg == STREAM) && res.out_ready;
    assign at_last   = (index_reg == CNT_W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            index_reg      <= '0;
            overrun_reg    <= 1'b0;
`ifdef SA_STREAM_DBUF_EN
            pend_valid_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            index_reg      <= index_next;
            overrun_reg    <= overrun_next;
`ifdef SA_STREAM_DBUF_EN
            pend_valid_reg <= pend_valid_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        index_next      = index_reg;
        overrun_next    = overrun_reg;
        shadow_load     = 1'b0;
`ifdef SA_STREAM_DBUF_EN
        pend_valid_next = pend_valid_reg;
        pend_load       = 1'b0;
        from_pend       = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (done_in) begin
                    shadow_load = 1'b1;
                    index_next  = '0;
                    state_next  = STREAM;
                end
            end
            STREAM: begin
                if (handshake && at_last) begin
                    // Final beat: a waiting matrix takes over with no bubble.
                    index_next = '0;
`ifdef SA_STREAM_DBUF_EN
                    if (pend_valid_reg) begin
                        shadow_load     = 1'b1;
                        from_pend       = 1'b1;
                        pend_valid_next = done_in;
                        pend_load       = done_in;
                    end else if (done_in) begin
                        shadow_load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    if (done_in) begin
                        shadow_load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
`endif
                end else begin
                    if (handshake) begin
                        index_next = index_reg + CNT_W'(1);
                    end
                    if (done_in) begin
`ifdef SA_STREAM_DBUF_EN
                        if (!pend_valid_reg) begin
                            pend_load       = 1'b1;
                            pend_valid_next = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
`else
                        overrun_next = 1'b1;
`endif
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // All stream outputs come from registered state; out_ready only steers the next state.
    assign res.out_valid = (state_reg == STREAM);
    assign res.out_data  = res.out_valid ? shadow_elem : '0;
    assign res.out_row   = res.out_valid ? IDX_W'(index_reg / CNT_W'(SIZE)) : '0;
    assign res.out_col   = res.out_valid ? IDX_W'(index_reg % CNT_W'(SIZE)) : '0;
    assign res.out_last  = res.out_valid && at_last;
    assign overrun       = overrun_reg;

`ifdef SA_STREAM_DBUF_EN
    assign busy = (state_reg == STREAM) || pend_valid_reg;
`else
    assign busy = (state_reg == STREAM);
`endif

endmodule

// File: tb/tb_sa_result_streamer.sv
// Randomized and scripted stimulus for sa_result_streamer checked against a queue-based model.
module tb_sa_result_streamer;

    localparam int SIZE = 2;
    localparam int DW   = 8;
    localparam int N    = SIZE * SIZE;
`ifdef SA_STREAM_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] C_in = '0;
    logic            done_in = 1'b0;
    logic            busy;
    logic            overrun;

    sa_result_streamer_if #(.SIZE(SIZE), .DATA_WIDTH(DW)) res_if ();

    sa_result_streamer #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .C_in    (C_in),
        .done_in (done_in),
        .res     (res_if.master),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            r;
        int            c;
        bit            l;
    } beat_t;

    beat_t           q[$];
    logic [N*DW-1:0] pend_mat;
    bit              pend_valid = 1'b0;
    bit              m_overrun  = 1'b0;
    int              beats_acc  = 0;
    int              checks     = 0;
    int              errors     = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void push_matrix(input logic [N*DW-1:0] m);
        beat_t b;
        for (int k = 0; k < N; k++) begin
            b.d = m[k*DW +: DW];
            b.r = k / SIZE;
            b.c = k % SIZE;
            b.l = (k == N - 1);
            q.push_back(b);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        pend_valid = 1'b0;
        m_overrun  = 1'b0;
    endfunction

    // One clock edge of the reference behaviour, from the inputs presented at that edge.
    function automatic void model_step(input bit d, input logic [N*DW-1:0] c, input bit r);
        bit    streaming = (q.size() > 0);
        bit    hs        = streaming && r;
        bit    fin       = 1'b0;
        bit    moved     = 1'b0;
        beat_t b;
        if (hs) begin
            b   = q.pop_front();
            fin = b.l;
            beats_acc++;
            $display("beat data=%02h row=%0d col=%0d last=%0d", b.d, b.r, b.c, b.l);
            if (fin && pend_valid) begin
                push_matrix(pend_mat);
                pend_valid = 1'b0;
                moved      = 1'b1;
            end
        end
        if (d) begin
            if (!streaming) begin
                push_matrix(c);
            end else if (fin) begin
                if (moved) begin
                    pend_mat   = c;
                    pend_valid = 1'b1;
                end else begin
                    push_matrix(c);
                end
            end else if (DBUF && !pend_valid) begin
                pend_mat   = c;
                pend_valid = 1'b1;
            end else begin
                m_overrun = 1'b1;
            end
        end
    endfunction

    task automatic check_outputs();
        bit exp_valid = (q.size() > 0);
        check("valid", {31'd0, res_if.out_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            check("data", {24'd0, res_if.out_data}, {24'd0, q[0].d});
            check("row",  {31'd0, res_if.out_row},  q[0].r);
            check("col",  {31'd0, res_if.out_col},  q[0].c);
            check("last", {31'd0, res_if.out_last}, {31'd0, q[0].l});
        end
        check("busy",    {31'd0, busy},    {31'd0, exp_valid || pend_valid});
        check("overrun", {31'd0, overrun}, {31'd0, m_overrun});
    endtask

    // Drive inputs (called just after a falling edge), apply the edge, then check.
    task automatic cycle(input bit d, input logic [N*DW-1:0] c, input bit r);
        done_in          = d;
        C_in             = c;
        res_if.out_ready = r;
        @(posedge clk);
        model_step(d, c, r);
        @(negedge clk);
        done_in = 1'b0;
        check_outputs();
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_data",    {24'd0, res_if.out_data}, 32'd0);
        check("rst_valid",   {31'd0, res_if.out_valid}, 32'd0);
        check("rst_rowcol",  {30'd0, res_if.out_row, res_if.out_col}, 32'd0);
        check("rst_last",    {31'd0, res_if.out_last}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        #2;
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [N*DW-1:0] rnd_mat;
    bit              ready_pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        res_if.out_ready = 1'b1;
        @(negedge clk);
        async_reset();

        // Idle noise: C_in moves without done_in
        for (int i = 0; i < 4; i++) cycle(1'b0, $urandom, 1'b1);
        check("idle_valid", {31'd0, res_if.out_valid}, 32'd0);

        // Single matrix with ready held high
        cycle(1'b1, 32'h04030201, 1'b1);
        check("t1_first", {24'd0, res_if.out_data}, 32'h01);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // Back-pressure with ready pattern 0,1,0,0,1
        beats_acc = 0;
        cycle(1'b1, 32'h04030201, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, ready_pat[i % 5]);
        check("t2_beats", beats_acc, 32'd4);

        // done_in coincident with the final handshake
        cycle(1'b1, 32'h04030201, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h08070605, 1'b1);
        check("t4_data",    {24'd0, res_if.out_data}, 32'h05);
        check("t4_overrun", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

        // Reset mid-stream after beat 02
        cycle(1'b1, 32'h04030201, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        async_reset();
        cycle(1'b1, 32'h0D0C0B0A, 1'b1);
        check("t5_first", {24'd0, res_if.out_data}, 32'h0A);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

        // done_in mid-stream at index 1
        cycle(1'b1, 32'h04030201, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'hAABBCCDD, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);
        check("t3_overrun", {31'd0, overrun}, {31'd0, !DBUF});

        // Randomized traffic, with a reset first so overrun starts clear
        async_reset();
        for (int i = 0; i < 400; i++) begin
            rnd_mat = $urandom;
            cycle(($urandom_range(0, 5) == 0), rnd_mat, ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
